bfp_to_fp16_packer: RTL and testbench

Converts one block-floating-point convolution result (signed accumulator plus combined block exponent) back into an IEEE-754 half-precision word. The block sits directly downstream of the 3x3 convolution datapath, closing the FP16 → BFP → FP16 loop so results can be written back to feature-map memory. It uses an iterative normalise / round / pack state machine with valid/ready handshakes on both sides.

---
 rtl/bfp_to_fp16_packer.sv | 145 ++++++++++++++
 tb/tb_bfp_to_fp16_packer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bfp_to_fp16_packer.sv
// Block-floating-point accumulator to IEEE-754 half-precision packer.
// Iterative normalise / round-to-nearest-even / pack with valid/ready on both sides.
module bfp_to_fp16_packer #(
  parameter int unsigned EXP_SIZE   = 5,
  parameter int unsigned MANT_SIZE  = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BIAS       = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*MANT_SIZE:0]     in_sum,
  input  logic [EXP_SIZE:0]        in_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_ovf,
  output logic                     out_unf
);

  localparam int unsigned SUM_W = 2 * MANT_SIZE + 1;
  localparam int unsigned CNT_W = $clog2(SUM_W);
  localparam int unsigned E_W   = 8;
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_SIZE) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_NORM, S_RND, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [SUM_W-1:0]        r_sum;
  logic [EXP_SIZE:0]       r_exp;
  logic [SUM_W-1:0]        r_mag;
  logic [CNT_W-1:0]        r_shcnt;
  logic                    r_sign;

  logic [SUM_W-1:0]        w_abs;
  logic signed [E_W-1:0]   w_e_raw;
  logic signed [E_W-1:0]   w_e_fin;
  logic [MANT_SIZE-1:0]    w_m;
  logic [MANT_SIZE:0]      w_m_inc;
  logic                    w_guard;
  logic                    w_sticky;
  logic                    w_ovf;
  logic                    w_unf;
  logic [DATA_WIDTH-1:0]   w_word;

  // Magnitude of the captured sum; the most negative value maps onto 2^20 unchanged.
  assign w_abs = r_sum[SUM_W-1] ? (~r_sum + SUM_W'(1)) : r_sum;

  // Rounding datapath, evaluated against the normalised magnitude in RND.
  assign w_e_raw  = E_W'(r_exp) + E_W'(2) - E_W'(BIAS) - E_W'(r_shcnt);
  assign w_m      = r_mag[SUM_W-2 -: MANT_SIZE];
  assign w_guard  = r_mag[SUM_W-2-MANT_SIZE];
  assign w_sticky = |r_mag[SUM_W-3-MANT_SIZE:0];
  assign w_m_inc  = {1'b0, w_m} + (MANT_SIZE+1)'(w_guard & (w_sticky | w_m[0]));
  assign w_e_fin  = w_e_raw + E_W'(w_m_inc[MANT_SIZE]);
  assign w_ovf    = (w_e_fin >= E_MAX);
  assign w_unf    = (w_e_fin <= E_ZERO);

  always_comb begin
    w_word = {r_sign, w_e_fin[EXP_SIZE-1:0], w_m_inc[MANT_SIZE-1:0]};
    if (w_ovf)
      w_word = {r_sign, {EXP_SIZE{1'b1}}, MANT_SIZE'(0)};
    else if (w_unf)
      w_word = {r_sign, (DATA_WIDTH-1)'(0)};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_ABS;
      S_ABS:  w_next = (w_abs == '0) ? S_OUT : S_NORM;
      S_NORM: if (r_mag[SUM_W-1]) w_next = S_RND;
      S_RND:  w_next = S_OUT;
      S_OUT:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  // Datapath and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum     <= '0;
      r_exp     <= '0;
      r_mag     <= '0;
      r_shcnt   <= '0;
      r_sign    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sum <= in_sum;
            r_exp <= in_exp;
          end
        end
        S_ABS: begin
          r_sign  <= r_sum[SUM_W-1];
          r_mag   <= w_abs;
          r_shcnt <= '0;
          if (w_abs == '0) begin
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_NORM: begin
          if (!r_mag[SUM_W-1]) begin
            r_mag   <= {r_mag[SUM_W-2:0], 1'b0};
            r_shcnt <= r_shcnt + CNT_W'(1);
          end
        end
        S_RND: begin
          out_data  <= w_word;
          out_ovf   <= w_ovf;
          out_unf   <= w_unf & ~w_ovf;
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfp_to_fp16_packer.sv
// Scoreboard bench for bfp_to_fp16_packer: directed vectors, latency, backpressure and reset.
module tb_bfp_to_fp16_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_sum;
  logic [5:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  typedef struct packed {
    logic [15:0] d;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  bfp_to_fp16_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: compare at every output handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        check("out_unf", 32'(out_unf), 32'(e.unf));
      end
    end
  end

  // Issue one input, push its expected result, and measure edges to out_valid.
  task automatic send(input logic [20:0] s, input logic [5:0] e, input logic [15:0] d,
                      input logic ovf, input logic unf, input int lat);
    int k;
    exp_t x;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    x.d = d; x.ovf = ovf; x.unf = unf;
    q.push_back(x);
    in_sum = s; in_exp = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accepted", 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 60) begin
      @(posedge clk); #1; k++;
    end
    check("latency", 32'(k), 32'(lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sum = '0; in_exp = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: sum, exp, expected word, ovf, unf, latency
    send(21'h040000, 6'd30, 16'h3C00, 1'b0, 1'b0, 5);
    send(21'h1C0000, 6'd30, 16'hBC00, 1'b0, 1'b0, 5);
    send(21'h0C0000, 6'd30, 16'h4200, 1'b0, 1'b0, 4);
    send(21'h0FFFFF, 6'd30, 16'h4400, 1'b0, 1'b0, 4);
    send(21'h040080, 6'd30, 16'h3C00, 1'b0, 1'b0, 5);
    send(21'h040180, 6'd30, 16'h3C02, 1'b0, 1'b0, 5);
    send(21'h040200, 6'd30, 16'h3C02, 1'b0, 1'b0, 5);
    send(21'h100000, 6'd30, 16'hC400, 1'b0, 1'b0, 3);
    send(21'h040000, 6'd60, 16'h7C00, 1'b1, 1'b0, 5);
    send(21'h1C0000, 6'd60, 16'hFC00, 1'b1, 1'b0, 5);
    send(21'h0FFFFF, 6'd63, 16'h7C00, 1'b1, 1'b0, 4);
    send(21'h040000, 6'd45, 16'h7800, 1'b0, 1'b0, 5);
    send(21'h040000, 6'd46, 16'h7C00, 1'b1, 1'b0, 5);
    send(21'h040000, 6'd16, 16'h0400, 1'b0, 1'b0, 5);
    send(21'h040000, 6'd15, 16'h0000, 1'b0, 1'b1, 5);
    send(21'h1C0000, 6'd15, 16'h8000, 1'b0, 1'b1, 5);
    send(21'h000001, 6'd0,  16'h0000, 1'b0, 1'b1, 23);
    send(21'h000000, 6'd30, 16'h0000, 1'b0, 1'b0, 1);

    // Backpressure with ignored input pulses while busy
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(21'h040000, 6'd30, 16'h3C00, 1'b0, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_sum = 21'h0C0000; in_exp = 6'd40;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h3C00);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    send(21'h0C0000, 6'd30, 16'h4200, 1'b0, 1'b0, 4);

    // Async reset in the middle of normalisation
    send(21'h040000, 6'd60, 16'h7C00, 1'b1, 1'b0, 5);
    @(posedge clk); #1;
    in_sum = 21'h000001; in_exp = 6'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_flags", 32'({out_ovf, out_unf}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(21'h040000, 6'd30, 16'h3C00, 1'b0, 1'b0, 5);

    repeat (5) @(posedge clk);
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
